// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared FSM state type for the bit-serial adder
package serial_add_ctrl_pkg;

  // Controller states: waiting for start, shifting bits through the cell, one-cycle result strobe
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between requester and serial adder
interface serial_add_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow, zero
  );

endinterface

// File: rtl/serial_add_ctrl_one_bit_ripple_carry.sv
// rtl/serial_add_ctrl_one_bit_ripple_carry.sv - single full-adder cell shared by every bit position
module one_bit_ripple_carry (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller, one result bit per clock LSB first
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave io
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cmsb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;
  logic             busy_q;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_d;

  one_bit_ripple_carry u_cell (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (sum_bit),
    .c_o (carry_out)
  );

  // Result register fills from the top so the last bit lands in the MSB
  assign res_d = {sum_bit, res_q[WIDTH-1:1]};

  // Sequencer: operand capture, bit-serial stepping, flag registration and done strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (io.start) begin
            // Subtraction becomes a + ~b with the +1 supplied through the initial carry
            a_q     <= io.a;
            b_q     <= io.sub ? ~io.b : io.b;
            carry_q <= io.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_out;
          cnt_q   <= cnt_q + CW'(1);
          // Carry into the sign bit, needed later for signed overflow
          if (cnt_q == CNT_MSB) begin
            cmsb_q <= carry_out;
          end
          if (cnt_q == CNT_LAST) begin
            cout_q  <= carry_out;
            ovf_q   <= cmsb_q ^ carry_out;
            zero_q  <= (res_d == '0);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.result   = res_q;
  assign io.cout     = cout_q;
  assign io.overflow = ovf_q;
  assign io.zero     = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and swept checks of the serial adder at WIDTH=8
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, zero, cout, result}
  function automatic logic [10:0] model(input logic [7:0] ta, input logic [7:0] tb_, input logic ts);
    logic [7:0] bb;
    logic [8:0] s9;
    logic       ovf;
    bb  = ts ? ~tb_ : tb_;
    s9  = {1'b0, ta} + {1'b0, bb} + {8'd0, ts};
    ovf = (ta[7] == bb[7]) && (s9[7] != ta[7]);
    return {ovf, (s9[7:0] == 8'd0), s9[8], s9[7:0]};
  endfunction

  // Launch one op from an IDLE sample point; mode 1 pokes start mid-run, mode 2 resets mid-run
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts, input int mode,
                       output int lat, output bit got_done, output int t0);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    bus.sub   = ts;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = 8'($urandom);
    bus.sub   = ~ts;
    lat = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 2 * W; k++) begin
      if (mode == 1 && k == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
      end
      if (mode == 2 && k == 4) rst_n = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      rst_n     = 1'b1;
      if (bus.done === 1'b1) begin
        lat = k;
        got_done = 1'b1;
        break;
      end
      if (mode == 2 && k == 4) break;
      check("busy_in_run", bus.busy, 1'b1);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] r, input logic c, input logic o, input logic z);
    check({tag, "_result"}, bus.result, r);
    check({tag, "_cout"}, bus.cout, c);
    check({tag, "_overflow"}, bus.overflow, o);
    check({tag, "_zero"}, bus.zero, z);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int lat;
    bit gd;
    int t0;
    int prev_t0;
    int pulses;
    logic [7:0] ra, rb;
    logic rs;
    logic [10:0] m;

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_res("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);

    // Reset outranks start at the same edge
    bus.start = 1'b1;
    bus.a     = 8'h11;
    @(posedge clk); #1;
    check("rst_over_start_busy", bus.busy, 1'b0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start_busy", bus.busy, 1'b0);

    // 0x7F + 0x01: signed overflow into the sign bit
    do_op(8'h7F, 8'h01, 1'b0, 0, lat, gd, t0);
    check("add7f_done", gd, 1'b1);
    check("add7f_latency", lat, W);
    check_res("add7f", 8'h80, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 1'b0);
    check("busy_after_done", bus.busy, 1'b0);
    check("hold_result_idle", bus.result, 8'h80);

    // 0xFF + 0x01: wraps to zero with carry
    do_op(8'hFF, 8'h01, 1'b0, 0, lat, gd, t0);
    check("addff_done", gd, 1'b1);
    check_res("addff", 8'h00, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // 0x05 - 0x07: borrow
    do_op(8'h05, 8'h07, 1'b1, 0, lat, gd, t0);
    check("sub57_done", gd, 1'b1);
    check_res("sub57", 8'hFE, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Start during RUN is ignored
    do_op(8'h10, 8'h20, 1'b0, 1, lat, gd, t0);
    check("ignore_done", gd, 1'b1);
    check("ignore_latency", lat, W);
    check_res("ignore", 8'h30, 1'b0, 1'b0, 1'b0);
    count_done(2 * W, pulses);
    check("ignore_extra_done", pulses, 0);
    check("ignore_busy_end", bus.busy, 1'b0);

    // Reset mid-run aborts with no done
    do_op(8'h12, 8'h34, 1'b0, 2, lat, gd, t0);
    check("abort_no_done", gd, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check_res("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    count_done(2 * W, pulses);
    check("abort_later_done", pulses, 0);
    do_op(8'h03, 8'h04, 1'b0, 0, lat, gd, t0);
    check("after_abort_done", gd, 1'b1);
    check("after_abort_latency", lat, W);
    check_res("after_abort", 8'h07, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back random sweep
    prev_t0 = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (i % 50 == 0) rb = ra;
      m = model(ra, rb, rs);
      do_op(ra, rb, rs, 0, lat, gd, t0);
      check("sweep_done", gd, 1'b1);
      check("sweep_latency", lat, W);
      if (i > 0) check("sweep_interval", t0 - prev_t0, W + 2);
      prev_t0 = t0;
      check_res("sweep", m[7:0], m[8], m[10], m[9]);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
